// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with an optional third read port, a hardwired zero register,
// same-cycle write bypass and a per-register busy scoreboard for decode-stage hazard detection.
module reg_file_sb #(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 5,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE_EN,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    input  logic [ADDR_W-1:0] OUT3ADDRESS,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2,
    output logic [WIDTH-1:0]  OUT3,
    input  logic              LOCK_EN,
    input  logic [ADDR_W-1:0] LOCK_ADDRESS,
    output logic              OUT1_BUSY,
    output logic              OUT2_BUSY,
    output logic              OUT3_BUSY
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = ZERO_REG != 0;
    localparam bit BP    = BYPASS != 0;

    logic [WIDTH-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W-1:0] raddr [3];
    logic [WIDTH-1:0]  rdata [3];
    logic [2:0]        rbusy;
    logic              wr_ok;
    logic              lk_ok;

    assign wr_ok = WRITE_EN && !(ZR && INADDRESS == '0);
    assign lk_ok = LOCK_EN && !(ZR && LOCK_ADDRESS == '0);

    // Lock is applied after the write so a new producer keeps the register busy.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) begin
                regs[INADDRESS] <= IN;
                busy[INADDRESS] <= 1'b0;
            end
            if (lk_ok) busy[LOCK_ADDRESS] <= 1'b1;
        end
    end

    assign raddr[0] = OUT1ADDRESS;
    assign raddr[1] = OUT2ADDRESS;
    assign raddr[2] = OUT3ADDRESS;

    for (genvar p = 0; p < 3; p++) begin : g_rd
        logic off, byp;
        assign off      = (p >= READ_PORTS) || (ZR && raddr[p] == '0);
        assign byp      = BP && WRITE_EN && INADDRESS == raddr[p];
        assign rdata[p] = off ? '0 : byp ? IN : regs[raddr[p]];
        assign rbusy[p] = off || byp ? 1'b0 : busy[raddr[p]];
    end

    assign OUT1      = rdata[0];
    assign OUT2      = rdata[1];
    assign OUT3      = rdata[2];
    assign OUT1_BUSY = rbusy[0];
    assign OUT2_BUSY = rbusy[1];
    assign OUT3_BUSY = rbusy[2];
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of the default file, a non-bypass copy and a wide 3-port copy.
module tb_reg_file_sb;
    logic        clk, rst_n;
    logic [31:0] in;
    logic [4:0]  ia, r1, r2, r3, la;
    logic        we, lk;
    logic [31:0] d1, d2, d3, n1, n2, n3;
    logic        db1, db2, db3, nb1, nb2, nb3;
    logic [63:0] w_in, w1, w2, w3;
    logic [3:0]  w_ia, w_r1, w_r2, w_r3, w_la;
    logic        w_we, w_lk, wb1, wb2, wb3;
    int          errors = 0;
    int          checks = 0;

    reg_file_sb u_dut (
        .CLK(clk), .RESET(rst_n), .IN(in), .INADDRESS(ia), .WRITE_EN(we),
        .OUT1ADDRESS(r1), .OUT2ADDRESS(r2), .OUT3ADDRESS(r3),
        .OUT1(d1), .OUT2(d2), .OUT3(d3), .LOCK_EN(lk), .LOCK_ADDRESS(la),
        .OUT1_BUSY(db1), .OUT2_BUSY(db2), .OUT3_BUSY(db3)
    );

    reg_file_sb #(.BYPASS(0)) u_nb (
        .CLK(clk), .RESET(rst_n), .IN(in), .INADDRESS(ia), .WRITE_EN(we),
        .OUT1ADDRESS(r1), .OUT2ADDRESS(r2), .OUT3ADDRESS(r3),
        .OUT1(n1), .OUT2(n2), .OUT3(n3), .LOCK_EN(lk), .LOCK_ADDRESS(la),
        .OUT1_BUSY(nb1), .OUT2_BUSY(nb2), .OUT3_BUSY(nb3)
    );

    reg_file_sb #(.WIDTH(64), .ADDR_W(4), .READ_PORTS(3)) u_wide (
        .CLK(clk), .RESET(rst_n), .IN(w_in), .INADDRESS(w_ia), .WRITE_EN(w_we),
        .OUT1ADDRESS(w_r1), .OUT2ADDRESS(w_r2), .OUT3ADDRESS(w_r3),
        .OUT1(w1), .OUT2(w2), .OUT3(w3), .LOCK_EN(w_lk), .LOCK_ADDRESS(w_la),
        .OUT1_BUSY(wb1), .OUT2_BUSY(wb2), .OUT3_BUSY(wb3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        {in, ia, we, lk, la, r1, r2, r3} = '0;
        {w_in, w_ia, w_we, w_lk, w_la, w_r1, w_r2, w_r3} = '0;
        #1 rst_n = 1'b0;
        repeat (2) cyc;
        r1 = 5'd0; r2 = 5'd5; #1;
        chk("rst_out1_a0", d1, 0);
        chk("rst_out2_a5", d2, 0);
        chk("rst_busy1", db1, 0);
        chk("rst_busy2", db2, 0);
        r1 = 5'd31; #1;
        chk("rst_out1_a31", d1, 0);
        w_r3 = 4'd15; #1;
        chk("rst_wide_out3", w3, 0);
        rst_n = 1'b1;
        cyc;
        we = 1; ia = 5'd5; in = 32'h12345678;
        cyc;
        we = 0; r1 = 5'd5; #1;
        chk("wr_reg5", d1, 64'h12345678);
        rst_n = 1'b0; #1;
        chk("async_rst_out1", d1, 0);
        cyc;
        rst_n = 1'b1;
        cyc;
        we = 1; ia = 5'd7; in = 32'hDEADBEEF;
        cyc;
        we = 0; r1 = 5'd7; r2 = 5'd7; #1;
        chk("rd7_out1", d1, 64'hDEADBEEF);
        chk("rd7_out2", d2, 64'hDEADBEEF);
        we = 1; ia = 5'd0; in = 32'hFFFFFFFF;
        cyc;
        we = 0; r1 = 5'd0; #1;
        chk("zero_reg", d1, 0);
        chk("zero_busy", db1, 0);
        we = 1; ia = 5'd3; in = 32'h11;
        cyc;
        we = 0; #1;
        we = 1; ia = 5'd3; in = 32'h22; r1 = 5'd3; #1;
        chk("bypass_on", d1, 64'h22);
        chk("bypass_off", n1, 64'h11);
        cyc;
        we = 0; #1;
        chk("post_wr_byp", d1, 64'h22);
        chk("post_wr_nobyp", n1, 64'h22);
        lk = 1; la = 5'd9; r2 = 5'd9; #1;
        chk("lock_not_same_cycle", db2, 0);
        cyc;
        chk("lock9_busy", db2, 1);
        chk("lock9_busy_nb", nb2, 1);
        cyc;
        lk = 0;
        we = 1; ia = 5'd9; in = 32'h99; #1;
        chk("wr9_busy_byp", db2, 0);
        chk("wr9_busy_nobyp", nb2, 1);
        chk("wr9_data_byp", d2, 64'h99);
        cyc;
        we = 0; #1;
        chk("after_wr9_busy", db2, 0);
        chk("after_wr9_busy_nb", nb2, 0);
        lk = 1; la = 5'd0;
        cyc;
        lk = 0; r2 = 5'd0; #1;
        chk("lock0_busy", db2, 0);
        lk = 1; la = 5'd4; we = 1; ia = 5'd4; in = 32'hAA;
        cyc;
        lk = 0; we = 0; r1 = 5'd4; #1;
        chk("lockwr4_data", d1, 64'hAA);
        chk("lockwr4_busy", db1, 1);
        lk = 1; la = 5'd6; we = 1; ia = 5'd4; in = 32'hBB;
        cyc;
        lk = 0; we = 0; r1 = 5'd4; r2 = 5'd6; #1;
        chk("split_data4", d1, 64'hBB);
        chk("split_busy4", db1, 0);
        chk("split_busy6", db2, 1);
        r3 = 5'd7; #1;
        chk("rp2_out3", d3, 0);
        r3 = 5'd6; #1;
        chk("rp2_out3_busy", db3, 0);
        w_we = 1; w_ia = 4'd15; w_in = 64'h0123456789ABCDEF; w_lk = 1; w_la = 4'd14;
        cyc;
        w_we = 0; w_lk = 0; w_r3 = 4'd15; #1;
        chk("wide_out3", w3, 64'h0123456789ABCDEF);
        chk("wide_out3_busy15", wb3, 0);
        w_r3 = 4'd14; #1;
        chk("wide_out3_busy14", wb3, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file for the RV32IM pipeline, successor to the fixed 32×32 two-read-port file. It adds configurable width/depth, an optional third read port, a hardwired zero register, same-cycle write-to-read bypass and a per-register busy scoreboard that lets the decode stage detect load-use and multi-cycle (MUL/DIV) hazards. It sits in the ID stage: reads feed the ID/EX latch, and the write port is driven by WB.

## Interface
- WIDTH, 32: data width of each register
- ADDR_W, 5: address width; depth = 2^ADDR_W
- READ_PORTS, 2: number of active read ports, 2 or 3; when 2, OUT3/OUT3_BUSY are driven 0
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, is never busy
- BYPASS, 1: 1 = same-cycle write data and busy-clear are visible on read ports

- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  reset; asynchronous, active-low
- IN  in  WIDTH  write data
- INADDRESS  in  ADDR_W  write address
- WRITE_EN  in  1  write strobe
- OUT1ADDRESS, OUT2ADDRESS, OUT3ADDRESS  in  ADDR_W each  read addresses
- OUT1, OUT2, OUT3  out  WIDTH each  read data
- LOCK_EN  in  1  mark LOCK_ADDRESS busy (issued long-latency producer)
- LOCK_ADDRESS  in  ADDR_W  register to mark busy
- OUT1_BUSY, OUT2_BUSY, OUT3_BUSY  out  1 each  scoreboard bit of the addressed register

## Operation
- Storage: 2^ADDR_W × WIDTH registers plus a 2^ADDR_W-bit busy vector.
- Reset (RESET=0): all registers and all busy bits cleared immediately, regardless of CLK; held while RESET=0. The write and lock inputs are ignored during reset.
- Write: on rising CLK with WRITE_EN=1, reg[INADDRESS] <= IN and busy[INADDRESS] <= 0. If ZERO_REG=1 and INADDRESS=0, nothing changes.
- Lock: on rising CLK with LOCK_EN=1, busy[LOCK_ADDRESS] <= 1. If ZERO_REG=1 and LOCK_ADDRESS=0, nothing changes.
- Lock and write to the same address in the same cycle: the data is written and busy ends at 1, because the lock wins (a new producer supersedes the retiring one). Lock and write to different addresses: both take effect.
- Read n (combinational):
  - If ZERO_REG=1 and OUTnADDRESS=0: OUTn=0 and OUTn_BUSY=0.
  - Otherwise, if BYPASS=1, WRITE_EN=1 and INADDRESS=OUTnADDRESS: OUTn=IN, and OUTn_BUSY = busy bit AND NOT that write.
  - Otherwise: OUTn=reg[addr] and OUTn_BUSY=busy[addr].
  - A same-cycle LOCK_EN does not affect OUTn_BUSY until after the edge.
- With BYPASS=0, reads show only the registered state.
- Any read port may alias any other or the write address; all ports resolve independently.
- The scoreboard is not a counter. Multiple locks to one register before a write leave a single busy bit set. A single write clears it.

## Timing
- Write and lock latency: 1 cycle (visible after the next rising edge).
- With BYPASS=1, read-after-write in the same cycle has zero latency.
- Reset values: all OUTn=0 and OUTn_BUSY=0 for every address.
- Reset asserted mid-cycle clears state asynchronously, and the outputs go to 0 within the same delta. On deassertion, the first rising edge with RESET=1 is the first one that can write or lock.
- There are no handshakes. WRITE_EN and LOCK_EN are sampled only at rising CLK.

## Test plan
- Reset, then read addresses 0, 5 and 31: all three read 0 and none are busy. Assert RESET=0 between edges after writing reg5=0x12345678: OUT1 reads 0 immediately.
- Write 0xDEADBEEF to reg 7, then read it on OUT1 and OUT2 the next cycle: both read 0xDEADBEEF. Write 0xFFFFFFFF to reg 0: OUT1ADDRESS=0 still reads 0.
- Bypass: with reg 3 = 0x11 and WRITE_EN=1, INADDRESS=3, IN=0x22 held before the edge: OUT1 reads 0x22 before the edge. Rerun with BYPASS=0: OUT1 reads 0x11 until the edge.
- Scoreboard:
  - Lock reg 9: OUT2_BUSY=1 from the next cycle. A write to reg 9 with BYPASS=1 drops OUT2_BUSY to 0 in the write cycle, and it stays 0 afterwards.
  - Lock reg 0: OUT2_BUSY stays 0.
- Simultaneous lock and write to reg 4 with IN=0xAA: afterwards reg4=0xAA and OUT1_BUSY=1. Lock reg 6 while writing reg 4: busy[6]=1 and busy[4]=0.
- Parameter sweep: WIDTH=64, ADDR_W=4, READ_PORTS=3. Write 0x0123456789ABCDEF to reg 15: OUT3 returns it. With READ_PORTS=2, OUT3 and OUT3_BUSY stay 0.
